sf_ascii_to_testing: RTL

SF_ASCII_TO_TESTING -- requirements
Module: sf_ascii_to_testing

---
 rtl/lcd_text_functions_pkg.sv | 12 +
 rtl/sf_ascii_cmd_pkg.sv | 14 +
 rtl/sf_ascii_to_testing.sv | 116 +++++++++++
 3 files changed

// File: rtl/lcd_text_functions_pkg.sv
// lcd_text_functions_pkg: conversions between hex nibbles and ASCII characters
package lcd_text_functions_pkg;
    function automatic logic [7:0] ascii_of_hdigit(input logic [3:0] i_d);
        return (i_d < 4'd10) ? 8'h30 + {4'h0, i_d} : 8'h37 + {4'h0, i_d};
    endfunction
    // {valid, nibble}; accepts 0-9, A-F, a-f only
    function automatic logic [4:0] ascii_to_hdigit(input logic [7:0] i_c);
        return (i_c >= 8'h30 && i_c <= 8'h39) ? {1'b1, i_c[3:0]} :
               ((i_c >= 8'h41 && i_c <= 8'h46) || (i_c >= 8'h61 && i_c <= 8'h66)) ? {1'b1, i_c[3:0] + 4'd9} :
               5'h00;
    endfunction
endpackage

// File: rtl/sf_ascii_cmd_pkg.sv
// sf_ascii_cmd_pkg: command parser state encoding and ASCII control characters
package sf_ascii_cmd_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAT_ARG,
        ST_PAT_END,
        ST_ADDR_ARG,
        ST_GO_END,
        ST_DISCARD
    } t_cmd_state;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] SP = 8'h20;
endpackage

// File: rtl/sf_ascii_to_testing.sv
// sf_ascii_to_testing: parses UART command lines into tester address, pattern and go pulses
module sf_ascii_to_testing
    import sf_ascii_cmd_pkg::*, lcd_text_functions_pkg::*;
#(
    parameter logic [7:0] parm_pattern_startval_a = 8'h00,
    parameter logic [7:0] parm_pattern_startval_b = 8'h00,
    parameter logic [7:0] parm_pattern_startval_c = 8'h00,
    parameter logic [7:0] parm_pattern_startval_d = 8'h00,
    parameter logic [7:0] parm_pattern_incrval_a  = 8'h01,
    parameter logic [7:0] parm_pattern_incrval_b  = 8'h01,
    parameter logic [7:0] parm_pattern_incrval_c  = 8'h01,
    parameter logic [7:0] parm_pattern_incrval_d  = 8'h01
) (
    input  logic        i_clk_40mhz,
    input  logic        i_rst_40mhz,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_tester_idle,
    output logic [31:0] o_addr_start,
    output logic [7:0]  o_pattern_start,
    output logic [7:0]  o_pattern_incr,
    output logic        o_cmd_addr,
    output logic        o_cmd_pattern,
    output logic        o_cmd_go,
    output logic        o_cmd_error
);
    t_cmd_state  r_state, w_state;
    logic [3:0]  r_cnt, w_cnt;
    logic [31:0] r_addr_sh, w_addr_sh, r_addr;
    logic [7:0]  r_ps_sh, w_ps_sh, r_pi_sh, w_pi_sh, r_ps, r_pi;
    logic [3:0]  r_pulse, w_pulse;
    logic [4:0]  w_hex;
    logic [7:0]  w_uc;
    logic        w_cr, w_ign;
    // pulse vector is {addr, pattern, go, error}; encodings keep it one-hot
    always_comb begin
        w_hex     = ascii_to_hdigit(i_rx_data);
        w_uc      = i_rx_data & 8'hDF;
        w_cr      = i_rx_data == CR;
        w_ign     = i_rx_data == SP || i_rx_data == LF;
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_addr_sh = r_addr_sh;
        w_ps_sh   = r_ps_sh;
        w_pi_sh   = r_pi_sh;
        w_pulse   = 4'b0000;
        if (i_rx_valid && !w_ign && w_cr) begin
            w_state = ST_IDLE;
            case (r_state)
                ST_IDLE:     w_pulse = 4'b0000;
                ST_PAT_END:  w_pulse = 4'b0100;
                ST_ADDR_ARG: w_pulse = (r_cnt == 4'd8) ? 4'b1000 : 4'b0001;
                ST_GO_END:   w_pulse = i_tester_idle ? 4'b0010 : 4'b0001;
                default:     w_pulse = 4'b0001;
            endcase
        end else if (i_rx_valid && !w_ign) begin
            w_state = ST_DISCARD;
            case (r_state)
                ST_IDLE: begin
                    w_cnt     = 4'd0;
                    w_addr_sh = 32'h0;
                    w_state   = (w_uc == 8'h50) ? ST_PAT_ARG :
                                (w_uc == 8'h41) ? ST_ADDR_ARG :
                                (w_uc == 8'h47) ? ST_GO_END : ST_DISCARD;
                end
                ST_PAT_ARG: if (w_uc >= 8'h41 && w_uc <= 8'h44) begin
                    w_state = ST_PAT_END;
                    w_ps_sh = (w_uc == 8'h41) ? parm_pattern_startval_a :
                              (w_uc == 8'h42) ? parm_pattern_startval_b :
                              (w_uc == 8'h43) ? parm_pattern_startval_c : parm_pattern_startval_d;
                    w_pi_sh = (w_uc == 8'h41) ? parm_pattern_incrval_a :
                              (w_uc == 8'h42) ? parm_pattern_incrval_b :
                              (w_uc == 8'h43) ? parm_pattern_incrval_c : parm_pattern_incrval_d;
                end
                ST_ADDR_ARG: if (w_hex[4] && r_cnt != 4'd8) begin
                    w_state   = ST_ADDR_ARG;
                    w_cnt     = r_cnt + 4'd1;
                    w_addr_sh = {r_addr_sh[27:0], w_hex[3:0]};
                end
                default: w_state = ST_DISCARD;
            endcase
        end
    end
    always_ff @(posedge i_clk_40mhz or negedge i_rst_40mhz) begin
        if (!i_rst_40mhz) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_addr_sh <= 32'h0;
            r_ps_sh   <= 8'h00;
            r_pi_sh   <= 8'h00;
            r_pulse   <= 4'b0000;
            r_addr    <= 32'h0;
            r_ps      <= parm_pattern_startval_a;
            r_pi      <= parm_pattern_incrval_a;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_addr_sh <= w_addr_sh;
            r_ps_sh   <= w_ps_sh;
            r_pi_sh   <= w_pi_sh;
            r_pulse   <= w_pulse;
            if (w_pulse[3]) r_addr <= r_addr_sh;
            if (w_pulse[2]) begin
                r_ps <= r_ps_sh;
                r_pi <= r_pi_sh;
            end
        end
    end
    assign o_addr_start    = r_addr;
    assign o_pattern_start = r_ps;
    assign o_pattern_incr  = r_pi;
    assign o_cmd_addr      = r_pulse[3];
    assign o_cmd_pattern   = r_pulse[2];
    assign o_cmd_go        = r_pulse[1];
    assign o_cmd_error     = r_pulse[0];
endmodule
